// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch front end:
// bus words, ibus bundles, decode-facing fetch register.
package fetch_stage_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;
   typedef u32          word_t;

   typedef struct packed {
      logic valid;
      u64   addr;
   } ibus_req_t;

   typedef struct packed {
      logic addr_ok;
      logic data_ok;
      u64   data;
   } ibus_resp_t;

   typedef struct packed {
      logic  valid;
      logic  bubble;
      u64    pc;
      word_t raw_instr;
      u64    iresp_data;
   } fetch_data_t;

   typedef enum logic [1:0] {
      REQ,
      HOLD,
      FLUSH
   } fetch_state_t;

   localparam fetch_data_t FETCH_BUBBLE = '{
      valid:      1'b0,
      bubble:     1'b1,
      pc:         '0,
      raw_instr:  '0,
      iresp_data: '0
   };

endpackage

// File: rtl/fetch_stage_instr_select.sv
// Picks the 32-bit instruction half of a 64-bit beat
// and packs it into a ready-to-issue fetch record.
module fetch_stage_instr_select
   import fetch_stage_pkg::*;
(
   input  u64          pc_i,
   input  u64          beat_i,
   output fetch_data_t pkt_o
);

   word_t instr;

   assign instr = pc_i[2] ? beat_i[63:32] : beat_i[31:0];

   always_comb begin
      pkt_o            = '0;
      pkt_o.valid      = 1'b1;
      pkt_o.bubble     = 1'b0;
      pkt_o.pc         = pc_i;
      pkt_o.raw_instr  = instr;
      pkt_o.iresp_data = beat_i;
   end

endmodule

// File: rtl/fetch_stage.sv
// PC owner and instruction-bus front end: one request
// in flight, stall holding buffer, redirect flushing.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter u64 RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output u64          ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  u64          iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  u64          redirect_pc,
   output fetch_data_t dataF,
   output u64          fetch_pc
);

   fetch_state_t state_q;
   u64           pc_q;
   u64           flush_addr_q;
   fetch_data_t  buf_q;
   fetch_data_t  dataf_q;

   u64           pc_inc;
   u64           redir_pc;
   fetch_data_t  pkt;
   logic         unused_addr_ok;

   assign unused_addr_ok = iresp_addr_ok;
   assign pc_inc         = pc_q + 64'd4;
   assign redir_pc       = {redirect_pc[63:2], 2'b00};

   fetch_stage_instr_select u_sel (
      .pc_i   (pc_q),
      .beat_i (iresp_data),
      .pkt_o  (pkt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= REQ;
         pc_q         <= RESET_PC;
         flush_addr_q <= RESET_PC;
         buf_q        <= '0;
         dataf_q      <= FETCH_BUBBLE;
      end else begin
         unique case (state_q)
            REQ: begin
               if (redirect_valid) begin
                  pc_q           <= redir_pc;
                  dataf_q.valid  <= 1'b0;
                  dataf_q.bubble <= 1'b1;
                  // the in-flight beat must still drain
                  if (!iresp_data_ok) begin
                     state_q      <= FLUSH;
                     flush_addr_q <= pc_q;
                  end
               end else if (iresp_data_ok) begin
                  if (stall) begin
                     buf_q   <= pkt;
                     state_q <= HOLD;
                  end else begin
                     dataf_q <= pkt;
                     pc_q    <= pc_inc;
                  end
               end else if (!stall) begin
                  dataf_q.valid  <= 1'b0;
                  dataf_q.bubble <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc_q           <= redir_pc;
                  buf_q          <= '0;
                  dataf_q.valid  <= 1'b0;
                  dataf_q.bubble <= 1'b1;
                  state_q        <= REQ;
               end else if (!stall) begin
                  dataf_q <= buf_q;
                  pc_q    <= pc_inc;
                  state_q <= REQ;
               end
            end
            FLUSH: begin
               if (redirect_valid) begin
                  pc_q           <= redir_pc;
                  dataf_q.valid  <= 1'b0;
                  dataf_q.bubble <= 1'b1;
               end
               if (iresp_data_ok) begin
                  state_q <= REQ;
               end
            end
            default: state_q <= REQ;
         endcase
      end
   end

   assign ireq_valid = !reset && (state_q != HOLD);
   assign ireq_addr  = (state_q == FLUSH) ? flush_addr_q
                                          : pc_q;
   assign dataF      = dataf_q;
   assign fetch_pc   = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a scoreboard
// of delivered instructions.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   u64          ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   u64          iresp_data;
   logic        stall;
   logic        redirect_valid;
   u64          redirect_pc;
   fetch_data_t dataF;
   u64          fetch_pc;

   fetch_stage #(.RESET_PC(64'h8000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_addr_ok  (iresp_addr_ok),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dataF          (dataF),
      .fetch_pc       (fetch_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ok;
      logic [63:0] data;
      logic        st;
      logic        rv;
      logic [63:0] rpc;
      logic        push;
      logic [63:0] ppc;
      logic        e_irv;
      logic [63:0] e_addr;
      logic        e_valid;
      logic        e_bub;
      logic [63:0] e_fpc;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [63:0] data;
   } exp_t;

   localparam logic [63:0] D0 = 64'h0000_0013_0000_0093;
   localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0033;
   localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
   localparam logic [63:0] D3 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D4 = 64'hAAAA_0001_BBBB_0002;
   localparam logic [63:0] WR = 64'hFFFF_FFFF_FFFF_FFFC;

   vec_t tbl_a[$];
   vec_t tbl_b[$];
   exp_t sbq[$];
   int   checks;
   int   failures;
   logic        pv;
   logic [63:0] ppc_prev;

   function automatic vec_t mk(
      logic ok, logic [63:0] data, logic st,
      logic rv, logic [63:0] rpc,
      logic push, logic [63:0] ppc,
      logic e_irv, logic [63:0] e_addr,
      logic e_valid, logic e_bub,
      logic [63:0] e_fpc);
      vec_t v;
      v.ok = ok; v.data = data; v.st = st;
      v.rv = rv; v.rpc = rpc;
      v.push = push; v.ppc = ppc;
      v.e_irv = e_irv; v.e_addr = e_addr;
      v.e_valid = e_valid; v.e_bub = e_bub;
      v.e_fpc = e_fpc;
      return v;
   endfunction

   function automatic logic [31:0] sel(
      logic [63:0] pc, logic [63:0] d);
      return pc[2] ? d[63:32] : d[31:0];
   endfunction

   task automatic chk(string name,
                      logic [63:0] act,
                      logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h",
                  name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int idx);
      exp_t e;
      string tag;
      tag = $sformatf("row%0d", idx);
      iresp_data_ok  = v.ok;
      iresp_data     = v.data;
      stall          = v.st;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      if (v.push) begin
         e.pc    = v.ppc;
         e.instr = sel(v.ppc, v.data);
         e.data  = v.data;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      chk({tag, "_irv"}, 64'(ireq_valid), 64'(v.e_irv));
      chk({tag, "_addr"}, ireq_addr, v.e_addr);
      chk({tag, "_valid"}, 64'(dataF.valid), 64'(v.e_valid));
      chk({tag, "_bubble"}, 64'(dataF.bubble), 64'(v.e_bub));
      chk({tag, "_fpc"}, fetch_pc, v.e_fpc);
      if (dataF.valid && (!pv || dataF.pc != ppc_prev)) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb_extra act=%h exp=none",
                     tag, dataF.pc);
         end else begin
            e = sbq.pop_front();
            chk({tag, "_sb_pc"}, dataF.pc, e.pc);
            chk({tag, "_sb_instr"}, 64'(dataF.raw_instr),
                64'(e.instr));
            chk({tag, "_sb_data"}, dataF.iresp_data, e.data);
         end
      end
      pv       = dataF.valid;
      ppc_prev = dataF.pc;
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, "_valid"}, 64'(dataF.valid), 64'd0);
      chk({tag, "_bubble"}, 64'(dataF.bubble), 64'd1);
      chk({tag, "_fpc"}, fetch_pc, 64'h8000_0000);
      chk({tag, "_irv"}, 64'(ireq_valid), 64'd0);
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      pv             = 1'b0;
      ppc_prev       = '0;
      reset          = 1'b0;
      iresp_addr_ok  = 1'b1;
      iresp_data_ok  = 1'b0;
      iresp_data     = '0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // ok data st rv rpc push ppc irv addr valid bub fpc
      tbl_a.push_back(mk(1, D0, 0, 0, 0, 1, 64'h8000_0000,
         1, 64'h8000_0004, 1, 0, 64'h8000_0004));
      tbl_a.push_back(mk(1, D0, 0, 0, 0, 1, 64'h8000_0004,
         1, 64'h8000_0008, 1, 0, 64'h8000_0008));
      for (int i = 0; i < 3; i++)
         tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0,
            1, 64'h8000_0008, 0, 1, 64'h8000_0008));
      tbl_a.push_back(mk(1, D1, 1, 0, 0, 1, 64'h8000_0008,
         0, 64'h8000_0008, 0, 1, 64'h8000_0008));
      tbl_a.push_back(mk(0, 0, 1, 0, 0, 0, 0,
         0, 64'h8000_0008, 0, 1, 64'h8000_0008));
      tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0,
         1, 64'h8000_000C, 1, 0, 64'h8000_000C));
      tbl_a.push_back(mk(0, 0, 0, 1, 64'h8000_0103, 0, 0,
         1, 64'h8000_000C, 0, 1, 64'h8000_0100));
      tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0,
         1, 64'h8000_000C, 0, 1, 64'h8000_0100));
      tbl_a.push_back(mk(1, D2, 0, 0, 0, 0, 0,
         1, 64'h8000_0100, 0, 1, 64'h8000_0100));
      tbl_a.push_back(mk(1, D3, 0, 0, 0, 1, 64'h8000_0100,
         1, 64'h8000_0104, 1, 0, 64'h8000_0104));
      tbl_a.push_back(mk(1, D3, 1, 0, 0, 0, 0,
         0, 64'h8000_0104, 1, 0, 64'h8000_0104));
      tbl_a.push_back(mk(0, 0, 1, 1, 64'h8000_0200, 0, 0,
         1, 64'h8000_0200, 0, 1, 64'h8000_0200));
      tbl_a.push_back(mk(1, D3, 0, 0, 0, 1, 64'h8000_0200,
         1, 64'h8000_0204, 1, 0, 64'h8000_0204));
      tbl_a.push_back(mk(1, D3, 0, 1, 64'h8000_0300, 0, 0,
         1, 64'h8000_0300, 0, 1, 64'h8000_0300));
      tbl_a.push_back(mk(1, D4, 0, 0, 0, 1, 64'h8000_0300,
         1, 64'h8000_0304, 1, 0, 64'h8000_0304));
      tbl_a.push_back(mk(0, 0, 1, 0, 0, 0, 0,
         1, 64'h8000_0304, 1, 0, 64'h8000_0304));
      tbl_a.push_back(mk(1, D4, 0, 0, 0, 1, 64'h8000_0304,
         1, 64'h8000_0308, 1, 0, 64'h8000_0308));
      tbl_a.push_back(mk(0, 0, 0, 1, 64'h8000_0400, 0, 0,
         1, 64'h8000_0308, 0, 1, 64'h8000_0400));
      tbl_a.push_back(mk(0, 0, 1, 0, 0, 0, 0,
         1, 64'h8000_0308, 0, 1, 64'h8000_0400));
      tbl_a.push_back(mk(0, 0, 0, 1, 64'h8000_0500, 0, 0,
         1, 64'h8000_0308, 0, 1, 64'h8000_0500));
      tbl_a.push_back(mk(1, D2, 0, 0, 0, 0, 0,
         1, 64'h8000_0500, 0, 1, 64'h8000_0500));
      tbl_a.push_back(mk(0, 0, 0, 1, 64'h8000_0600, 0, 0,
         1, 64'h8000_0500, 0, 1, 64'h8000_0600));

      tbl_b.push_back(mk(1, D0, 0, 0, 0, 1, 64'h8000_0000,
         1, 64'h8000_0004, 1, 0, 64'h8000_0004));
      tbl_b.push_back(mk(1, D0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD,
         0, 0, 1, WR, 0, 1, WR));
      tbl_b.push_back(mk(1, D3, 0, 0, 0, 1, WR,
         1, 64'd0, 1, 0, 64'd0));
      tbl_b.push_back(mk(0, 0, 0, 0, 0, 0, 0,
         1, 64'd0, 0, 1, 64'd0));

      #2 reset = 1'b1;
      #1 chk_reset_state("rst0");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rel0_irv", 64'(ireq_valid), 64'd1);
      chk("rel0_addr", ireq_addr, 64'h8000_0000);

      foreach (tbl_a[i]) step(tbl_a[i], i);

      #2 reset = 1'b1;
      #1 chk_reset_state("rst1");
      pv = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rel1_irv", 64'(ireq_valid), 64'd1);
      chk("rel1_addr", ireq_addr, 64'h8000_0000);

      foreach (tbl_b[i]) step(tbl_b[i], 100 + i);

      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL sb_left act=%0d exp=0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=done");
      $fatal(1);
   end

endmodule
